// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register.
//
// One WIDTH-bit register covering SISO, SIPO, PISO and PIPO use. It supports
// synchronous set and clear of the whole register, hold, shift right, shift
// left and parallel load. A saturating counter tracks the shifts made since the
// last load, set, clear or reset, so that a serializer knows when the word has
// been fully drained.
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   synchronous active-low reset (overrides everything)
//   en        in   mode enable; 0 = hold (set/clr still act)
//   mode      in   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sin_r     in   serial in for right shift, enters q[WIDTH-1]
//   sin_l     in   serial in for left shift, enters q[0]
//   pdata_in  in   parallel load data
//   set       in   synchronous set, q <= all ones
//   clr       in   synchronous clear, q <= all zeros
//   q         out  register contents
//   sout_r    out  serial out for right shift (q[0])
//   sout_l    out  serial out for left shift (q[WIDTH-1])
//   shift_cnt out  shifts since last load/set/clr/reset, saturating at WIDTH
//   drained   out  registered, high while shift_cnt == WIDTH
//   err       out  one-cycle pulse after an edge that saw set and clr together
module univ_shift_reg #(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         sin_r,
    input  logic                         sin_l,
    input  logic [WIDTH-1:0]             pdata_in,
    input  logic                         set,
    input  logic                         clr,
    output logic [WIDTH-1:0]             q,
    output logic                         sout_r,
    output logic                         sout_l,
    output logic [$clog2(WIDTH+1)-1:0]   shift_cnt,
    output logic                         drained,
    output logic                         err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHR   = 2'b01,
        MODE_SHL   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    logic [WIDTH-1:0] data_q,    data_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic             drained_q, drained_d;
    logic             err_q,     err_d;
    logic             shift_do;

    always_comb begin
        data_d    = data_q;
        cnt_d     = cnt_q;
        drained_d = drained_q;
        err_d     = 1'b0;
        shift_do  = 1'b0;

        if (set && clr) begin
            // Conflicting request: keep state intact and flag it next cycle.
            err_d = 1'b1;
        end else if (clr) begin
            data_d    = '0;
            cnt_d     = '0;
            drained_d = 1'b0;
        end else if (set) begin
            data_d    = '1;
            cnt_d     = '0;
            drained_d = 1'b0;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_SHR: begin
                    data_d   = {sin_r, data_q[WIDTH-1:1]};
                    shift_do = 1'b1;
                end
                MODE_SHL: begin
                    data_d   = {data_q[WIDTH-2:0], sin_l};
                    shift_do = 1'b1;
                end
                MODE_LOAD: begin
                    data_d    = pdata_in;
                    cnt_d     = '0;
                    drained_d = 1'b0;
                end
                default: ;
            endcase

            // Count saturates; data keeps moving once the count is full.
            if (shift_do) begin
                if (cnt_q != CNT_FULL) begin
                    cnt_d = cnt_q + 1'b1;
                end
                drained_d = (cnt_d == CNT_FULL);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q    <= RESET_VAL;
            cnt_q     <= '0;
            drained_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            drained_q <= drained_d;
            err_q     <= err_d;
        end
    end

    assign q         = data_q;
    assign sout_r    = data_q[0];
    assign sout_l    = data_q[WIDTH-1];
    assign shift_cnt = cnt_q;
    assign drained   = drained_q;
    assign err       = err_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] cnt;
        logic       drained;
        logic       err;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n, en, sin_r, sin_l, set, clr;
    logic [1:0]       mode;
    logic [WIDTH-1:0] pdata_in, q;
    logic             sout_r, sout_l, drained, err;
    logic [3:0]       shift_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sin_r(sin_r),
        .sin_l(sin_l), .pdata_in(pdata_in), .set(set), .clr(clr), .q(q),
        .sout_r(sout_r), .sout_l(sout_l), .shift_cnt(shift_cnt),
        .drained(drained), .err(err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst_n = 1'b1; en = 1'b1; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0;
        set = 1'b0; clr = 1'b0; pdata_in = '0;
    endtask

    task automatic test_reset();
        exp_t e, obs;
        idle_inputs();
        rst_n = 1'b0; mode = 2'b11; pdata_in = 8'hA5;
        sb.push_back('{q: 8'h00, cnt: 4'd0, drained: 1'b0, err: 1'b0});
        tick();
        obs = {q, shift_cnt, drained, err};
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset: got q=%h cnt=%0d drained=%b err=%b, expected q=%h cnt=%0d drained=%b err=%b",
                     obs.q, obs.cnt, obs.drained, obs.err, e.q, e.cnt, e.drained, e.err);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_piso();
        exp_t e, obs;
        logic [7:0] word = 8'hA5;
        idle_inputs();
        mode = 2'b11; pdata_in = word;
        sb.push_back('{q: word, cnt: 4'd0, drained: 1'b0, err: 1'b0});
        tick();
        obs = {q, shift_cnt, drained, err};
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL piso_load: got q=%h cnt=%0d drained=%b err=%b, expected q=%h cnt=%0d drained=%b err=%b",
                     obs.q, obs.cnt, obs.drained, obs.err, e.q, e.cnt, e.drained, e.err);
        end
        checks++;
        if (sout_l !== 1'b1) begin
            errors++;
            $display("FAIL piso_sout_l: got %b, expected 1", sout_l);
        end
        mode = 2'b01; sin_r = 1'b0;
        for (int i = 0; i < 9; i++) begin
            checks++;
            if (i < 8 && sout_r !== word[i]) begin
                errors++;
                $display("FAIL piso_sout_r bit %0d: got %b, expected %b", i, sout_r, word[i]);
            end
            sb.push_back('{q: (i < 8) ? (word >> (i + 1)) : 8'h00,
                           cnt: (i < 8) ? 4'(i + 1) : 4'd8,
                           drained: (i >= 7), err: 1'b0});
            tick();
            obs = {q, shift_cnt, drained, err};
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL piso_shift %0d: got q=%h cnt=%0d drained=%b err=%b, expected q=%h cnt=%0d drained=%b err=%b",
                         i + 1, obs.q, obs.cnt, obs.drained, obs.err, e.q, e.cnt, e.drained, e.err);
            end
        end
        // Clear while drained must drop drained.
        mode = 2'b00; clr = 1'b1;
        sb.push_back('{q: 8'h00, cnt: 4'd0, drained: 1'b0, err: 1'b0});
        tick();
        obs = {q, shift_cnt, drained, err};
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL piso_clr_drained: got q=%h cnt=%0d drained=%b err=%b, expected q=%h cnt=%0d drained=%b err=%b",
                     obs.q, obs.cnt, obs.drained, obs.err, e.q, e.cnt, e.drained, e.err);
        end
        clr = 1'b0;
    endtask

    task automatic test_sipo();
        exp_t e, obs;
        logic [7:0] bits = 8'b1101_0011; // bits[0] shifted first: 1,1,0,0,1,0,1,1
        logic [7:0] model = 8'h00;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            sin_l = bits[i];
            model = {model[6:0], bits[i]};
            sb.push_back('{q: model, cnt: 4'(i + 1), drained: (i == 7), err: 1'b0});
        end
        for (int i = 0; i < 8; i++) begin
            sin_l = bits[i];
            tick();
            obs = {q, shift_cnt, drained, err};
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL sipo_shift %0d: got q=%h cnt=%0d drained=%b err=%b, expected q=%h cnt=%0d drained=%b err=%b",
                         i + 1, obs.q, obs.cnt, obs.drained, obs.err, e.q, e.cnt, e.drained, e.err);
            end
        end
        checks++;
        if (q !== 8'hCB) begin
            errors++;
            $display("FAIL sipo_word: got q=%h, expected q=cb", q);
        end
        mode = 2'b11; pdata_in = 8'h3C;
        sb.push_back('{q: 8'h3C, cnt: 4'd0, drained: 1'b0, err: 1'b0});
        tick();
        obs = {q, shift_cnt, drained, err};
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL sipo_reload: got q=%h cnt=%0d drained=%b err=%b, expected q=%h cnt=%0d drained=%b err=%b",
                     obs.q, obs.cnt, obs.drained, obs.err, e.q, e.cnt, e.drained, e.err);
        end
    endtask

    task automatic test_set_clr();
        exp_t e, obs;
        idle_inputs();
        mode = 2'b11; pdata_in = 8'hB4;
        tick();
        mode = 2'b01; sin_r = 1'b0;
        sb.push_back('{q: 8'h5A, cnt: 4'd1, drained: 1'b0, err: 1'b0});
        sb.push_back('{q: 8'hFF, cnt: 4'd0, drained: 1'b0, err: 1'b0});
        sb.push_back('{q: 8'h00, cnt: 4'd0, drained: 1'b0, err: 1'b0});
        for (int i = 0; i < 3; i++) begin
            set = (i == 1);
            clr = (i == 2);
            tick();
            obs = {q, shift_cnt, drained, err};
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL set_clr step %0d: got q=%h cnt=%0d drained=%b err=%b, expected q=%h cnt=%0d drained=%b err=%b",
                         i, obs.q, obs.cnt, obs.drained, obs.err, e.q, e.cnt, e.drained, e.err);
            end
        end
        set = 1'b0; clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e, obs;
        idle_inputs();
        mode = 2'b11; pdata_in = 8'h4B;
        tick();
        mode = 2'b10; sin_l = 1'b0;
        tick();
        // q = 96, cnt = 1. Two set&&clr edges, then en=0 shifts, then en=0 set.
        sb.push_back('{q: 8'h96, cnt: 4'd1, drained: 1'b0, err: 1'b1});
        sb.push_back('{q: 8'h96, cnt: 4'd1, drained: 1'b0, err: 1'b1});
        sb.push_back('{q: 8'h96, cnt: 4'd1, drained: 1'b0, err: 1'b0});
        sb.push_back('{q: 8'h96, cnt: 4'd1, drained: 1'b0, err: 1'b0});
        sb.push_back('{q: 8'hFF, cnt: 4'd0, drained: 1'b0, err: 1'b0});
        mode = 2'b01; sin_r = 1'b1;
        for (int i = 0; i < 5; i++) begin
            en  = (i < 2);
            set = (i < 2) || (i == 4);
            clr = (i < 2);
            tick();
            obs = {q, shift_cnt, drained, err};
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL set_and_clr step %0d: got q=%h cnt=%0d drained=%b err=%b, expected q=%h cnt=%0d drained=%b err=%b",
                         i, obs.q, obs.cnt, obs.drained, obs.err, e.q, e.cnt, e.drained, e.err);
            end
        end
        set = 1'b0; clr = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset_mid_drain();
        exp_t e, obs;
        idle_inputs();
        mode = 2'b11; pdata_in = 8'hF0;
        tick();
        mode = 2'b01; sin_r = 1'b0;
        sb.push_back('{q: 8'h78, cnt: 4'd1, drained: 1'b0, err: 1'b0});
        sb.push_back('{q: 8'h3C, cnt: 4'd2, drained: 1'b0, err: 1'b0});
        sb.push_back('{q: 8'h1E, cnt: 4'd3, drained: 1'b0, err: 1'b0});
        sb.push_back('{q: 8'h00, cnt: 4'd0, drained: 1'b0, err: 1'b0});
        sb.push_back('{q: 8'h80, cnt: 4'd1, drained: 1'b0, err: 1'b0});
        for (int i = 0; i < 5; i++) begin
            rst_n = (i != 3);
            sin_r = (i == 4);
            tick();
            obs = {q, shift_cnt, drained, err};
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid_drain step %0d: got q=%h cnt=%0d drained=%b err=%b, expected q=%h cnt=%0d drained=%b err=%b",
                         i, obs.q, obs.cnt, obs.drained, obs.err, e.q, e.cnt, e.drained, e.err);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_piso();
        test_sipo();
        test_set_clr();
        test_back_to_back();
        test_reset_mid_drain();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised universal shift register.
- Successor to the single-bit set/reset storage element. Generalises it to WIDTH bits with synchronous whole-register set/clear, hold, shift-right, shift-left and parallel load.
- Supports SISO, SIPO, PISO and PIPO use from one block.
- Tracks shifts since the last load so serializer users know when the word is fully drained.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RESET_VAL, {WIDTH{1'b0}}, value of q after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  mode enable; 0 = hold (set/clr still act).
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial in for right shift, enters q[WIDTH-1].
- sin_l  input  1  serial in for left shift, enters q[0].
- pdata_in  input  WIDTH  parallel load data.
- set  input  1  synchronous set, q <= all ones.
- clr  input  1  synchronous clear, q <= all zeros.
- q  output  WIDTH  register contents.
- sout_r  output  1  serial out for right shift, equals q[0].
- sout_l  output  1  serial out for left shift, equals q[WIDTH-1].
- shift_cnt  output  $clog2(WIDTH+1)  shifts since last load/set/clr/reset, saturating.
- drained  output  1  high when shift_cnt == WIDTH.
- err  output  1  one-cycle pulse, set and clr sampled high together.

Behaviour:
- All state updates on posedge clk. No asynchronous paths.
- sout_r and sout_l are combinational taps of q.
- Reset (rst_n == 0 at the edge):
  - q = RESET_VAL, shift_cnt = 0, drained = 0, err = 0.
  - Reset overrides every other input.
- Priority per edge, highest first:
  1. Reset.
  2. set && clr: q holds, shift_cnt holds, err = 1 for the following cycle. Never an X state.
  3. clr: q = 0, shift_cnt = 0.
  4. set: q = all ones, shift_cnt = 0.
  5. en == 0: q and shift_cnt hold.
  6. mode decode.
- mode decode:
  - 00: hold.
  - 01: q <= {sin_r, q[WIDTH-1:1]}.
  - 10: q <= {q[WIDTH-2:0], sin_l}.
  - 11: q <= pdata_in, shift_cnt = 0.
- shift_cnt:
  - +1 on each executed shift (01 or 10).
  - Saturates at WIDTH and never wraps. Further shifts still move data.
- drained is registered and asserts the same edge shift_cnt reaches WIDTH.
  - Deasserts on the edge of any load, set, clr or reset.
- err:
  - 0 on every cycle not preceded by a set&&clr edge.
  - Back-to-back set&&clr cycles keep err high continuously.
- Load and shift are mutually exclusive by encoding, so no data collision case exists.
- Mid-operation reset: reset during a drain discards contents and count. Next cycle starts from RESET_VAL with shift_cnt = 0.
- Latency: every operation is visible on q one cycle after the sampling edge.

Test Plan:
- Reset: rst_n = 0 with mode = 11, pdata_in = 8'hA5 -> q = 8'h00, shift_cnt = 0, drained = 0, err = 0.
- PISO: load 8'hA5, then 8 cycles mode = 01, sin_r = 0 -> sout_r sequence 1,0,1,0,0,1,0,1. After the 8th shift: q = 8'h00, shift_cnt = 8, drained = 1. A 9th shift leaves shift_cnt = 8.
- SIPO: from reset, 8 cycles mode = 10 with sin_l bits 1,1,0,0,1,0,1,1 -> q = 8'hCB, drained = 1. A load of 8'h3C then gives q = 8'h3C, shift_cnt = 0, drained = 0.
- Set/clear priority: with q = 8'h5A, en = 1, mode = 01 and set = 1 -> q = 8'hFF, shift_cnt = 0. With clr = 1, set = 0, same mode -> q = 8'h00.
- Invalid set&clr: with q = 8'h96, set = clr = 1 for 2 cycles -> q stays 8'h96, err high for exactly 2 cycles starting one cycle later. With en = 0, mode = 01 -> q unchanged, shift_cnt unchanged.
- Reset mid-drain: load 8'hF0, shift right 3 times, rst_n = 0 for one edge -> q = 8'h00, shift_cnt = 0. The next shift gives shift_cnt = 1.
